// File: rtl/round_ctrl_if.sv
// Bus between the keyboard/tank datapaths and the round referee.
// Carries the keycode, tile positions and all round-control outputs.
interface round_ctrl_if;
  logic        [7:0]  keycode;
  logic signed [31:0] Tank1X, Tank1Y, Tank2X, Tank2Y;
  logic signed [31:0] Bul1X, Bul1Y, Bul2X, Bul2Y;
  logic               tank_rst;
  logic               run_en;
  logic        [3:0]  score1, score2;
  logic        [2:0]  state;
  logic        [1:0]  winner;

  modport master (
    output keycode, Tank1X, Tank1Y, Tank2X, Tank2Y, Bul1X, Bul1Y, Bul2X, Bul2Y,
    input  tank_rst, run_en, score1, score2, state, winner
  );

  modport slave (
    input  keycode, Tank1X, Tank1Y, Tank2X, Tank2Y, Bul1X, Bul1Y, Bul2X, Bul2Y,
    output tank_rst, run_en, score1, score2, state, winner
  );
endinterface

// File: rtl/round_ctrl.sv
// Round sequencer and referee for the two-tank game: detects bullet hits,
// keeps scores and runs IDLE/COUNTDOWN/PLAY/HIT_PAUSE/GAME_OVER.
module round_ctrl #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned COUNT_FRAMES = 180,
  parameter int unsigned PAUSE_FRAMES = 120,
  parameter logic [7:0]  START_KEY    = 8'h2C
) (
  input  logic         frame_clk,
  input  logic         Reset,
  round_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    HIT_PAUSE = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam int unsigned MAXF = (COUNT_FRAMES > PAUSE_FRAMES) ? COUNT_FRAMES : PAUSE_FRAMES;
  localparam int unsigned CW   = $clog2(MAXF + 1);

  state_t        st;
  logic [CW-1:0] cnt;
  logic [7:0]    prev_key;
  logic          tank_rst_q, run_en_q;
  logic [3:0]    score1_q, score2_q;
  logic [1:0]    winner_q;

  logic       start, hit1, hit2, any_hit;
  logic [3:0] nxt1, nxt2;

  always_comb begin
    start   = (bus.keycode == START_KEY) && (prev_key != START_KEY);
    hit1    = !bus.Bul1X[31] && !bus.Bul1Y[31] &&
              (bus.Bul1X == bus.Tank2X) && (bus.Bul1Y == bus.Tank2Y);
    hit2    = !bus.Bul2X[31] && !bus.Bul2Y[31] &&
              (bus.Bul2X == bus.Tank1X) && (bus.Bul2Y == bus.Tank1Y);
    any_hit = hit1 || hit2;
    nxt1    = score1_q;
    nxt2    = score2_q;
    // A simultaneous hit is a draw: neither score moves.
    if (hit1 && !hit2) nxt1 = score1_q + 4'd1;
    if (hit2 && !hit1) nxt2 = score2_q + 4'd1;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      st         <= IDLE;
      cnt        <= '0;
      prev_key   <= '0;
      tank_rst_q <= 1'b0;
      run_en_q   <= 1'b0;
      score1_q   <= '0;
      score2_q   <= '0;
      winner_q   <= '0;
    end else begin
      prev_key   <= bus.keycode;
      tank_rst_q <= 1'b0;
      case (st)
        IDLE, GAME_OVER: begin
          run_en_q <= 1'b0;
          if (start) begin
            st         <= COUNTDOWN;
            score1_q   <= '0;
            score2_q   <= '0;
            winner_q   <= '0;
            tank_rst_q <= 1'b1;
            cnt        <= CW'(COUNT_FRAMES - 1);
          end
        end
        COUNTDOWN: begin
          if (cnt == '0) begin
            st       <= PLAY;
            run_en_q <= 1'b1;
          end else begin
            run_en_q <= 1'b0;
            cnt      <= cnt - 1'b1;
          end
        end
        PLAY: begin
          run_en_q <= 1'b1;
          if (any_hit) begin
            run_en_q <= 1'b0;
            score1_q <= nxt1;
            score2_q <= nxt2;
            cnt      <= CW'(PAUSE_FRAMES - 1);
            if (nxt1 == 4'(WIN_SCORE)) begin
              st       <= GAME_OVER;
              winner_q <= 2'd1;
            end else if (nxt2 == 4'(WIN_SCORE)) begin
              st       <= GAME_OVER;
              winner_q <= 2'd2;
            end else begin
              st <= HIT_PAUSE;
            end
          end
        end
        HIT_PAUSE: begin
          run_en_q <= 1'b0;
          if (cnt == '0) begin
            st         <= COUNTDOWN;
            tank_rst_q <= 1'b1;
            cnt        <= CW'(COUNT_FRAMES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          st       <= IDLE;
          run_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tank_rst = tank_rst_q;
  assign bus.run_en   = run_en_q;
  assign bus.score1   = score1_q;
  assign bus.score2   = score2_q;
  assign bus.state    = st;
  assign bus.winner   = winner_q;

endmodule
